// File: rtl/sr_pkg.sv
// Shared constants and helpers for the SR flag bank arbiter.
package sr_pkg;

  localparam logic OP_CLR = 1'b0;
  localparam logic OP_SET = 1'b1;

  localparam int IDXW_DEF = 3;
  typedef logic [IDXW_DEF-1:0] flag_idx_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sr_bank_arbiter_rr.sv
// Combinational round-robin pick: lowest requester at or after ptr wins.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            vld_o
);

  logic [NREQ-1:0] rot;
  logic [NREQ-1:0] first_oh;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  assign rot      = NREQ'({req_i, req_i} >> ptr_i);
  assign first_oh = rot & (~rot + NREQ'(1));
  assign gnt_o    = NREQ'(({first_oh, first_oh} << ptr_i) >> NREQ);
  assign vld_o    = |req_i;

endmodule

// File: rtl/sr_bank_arbiter.sv
// Round-robin sequencer applying one set/clear per clock to a bank of SR flags.
module sr_bank_arbiter
  import sr_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int NFLAGS = 8,
  parameter int IDXW   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      op_set,
  input  logic [NREQ*IDXW-1:0] idx,
  output logic [NREQ-1:0]      gnt,
  output logic [NFLAGS-1:0]    flags,
  output logic                 conflict,
  output logic                 idx_err
);

  localparam int PW = (clog2(NREQ) < 1) ? 1 : clog2(NREQ);
  localparam logic [IDXW:0] NFL = (IDXW+1)'(NFLAGS);

  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NFLAGS-1:0] flags_q, flags_d;
  logic [NREQ-1:0]   gnt_q;
  logic              conflict_q, conflict_d;
  logic              idx_err_q, idx_err_d;

  logic [NREQ-1:0]   win_oh;
  logic              win_vld;
  logic [IDXW-1:0]   w_idx;
  logic              w_op;
  logic              in_range;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (win_oh),
    .vld_o (win_vld)
  );

  always_comb begin
    w_idx      = '0;
    w_op       = OP_CLR;
    ptr_d      = ptr_q;
    flags_d    = flags_q;
    conflict_d = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_oh[i]) begin
        w_idx = idx[i*IDXW +: IDXW];
        w_op  = op_set[i];
        // Explicit wrap keeps non-power-of-2 NREQ inside 0..NREQ-1.
        ptr_d = (i == NREQ-1) ? '0 : PW'(i + 1);
      end
    end
    in_range  = ({1'b0, w_idx} < NFL);
    idx_err_d = win_vld && !in_range;
    for (int f = 0; f < NFLAGS; f++) begin
      if (win_vld && in_range && (w_idx == IDXW'(f))) flags_d[f] = w_op;
    end
    // Losers with the opposite op on the same flag stay pending; flag it.
    for (int j = 0; j < NREQ; j++) begin
      if (win_vld && !win_oh[j] && req[j] &&
          (idx[j*IDXW +: IDXW] == w_idx) && (op_set[j] != w_op))
        conflict_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= '0;
      flags_q    <= '0;
      gnt_q      <= '0;
      conflict_q <= 1'b0;
      idx_err_q  <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      flags_q    <= flags_d;
      gnt_q      <= win_oh;
      conflict_q <= conflict_d;
      idx_err_q  <= idx_err_d;
    end
  end

  assign gnt      = gnt_q;
  assign flags    = flags_q;
  assign conflict = conflict_q;
  assign idx_err  = idx_err_q;

endmodule
